song_recorder: RTL and testbench

Upstream stage of the song memory controller. Captures one 60-note song from the live keyboard note code at the playback note rate, and writes it into song memory through the controller's `writeNote` / `protectionChange` handshakes. It first writes the song's protection byte, then writes each note at `noteOffset` 0..59. The top level holds `user` and `song` stable at the memory controller while `busy` is high.

---
 rtl/song_recorder_pkg.sv | 26 ++
 rtl/song_recorder_tick.sv | 28 ++
 rtl/song_recorder.sv | 133 +++++++++++++
 tb/tb_song_recorder.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/song_recorder_pkg.sv
// Shared definitions for the song recorder and the song memory controller:
// song geometry, handshake gap length, recorder states and protection encoding.
package song_recorder_pkg;

  localparam int NOTES_PER_SONG = 60;
  localparam int HS_GAP_CYCLES  = 2;

  localparam logic PRIV = 1'b1;
  localparam logic PUB  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROT_REQ,
    ST_PROT_GAP,
    ST_RECORD,
    ST_NOTE_REQ,
    ST_NOTE_GAP,
    ST_DONE
  } rec_state_t;

  // Protection byte as stored by the memory controller.
  function automatic logic [7:0] prot_byte(input logic priv_sel);
    return (priv_sel == PRIV) ? {7'b0, PRIV} : {7'b0, PUB};
  endfunction

endpackage

// File: rtl/song_recorder_tick.sv
// Free-running note-period counter with clear and enable; emits a one-cycle
// tick on the terminal count so note spacing is exactly PERIOD cycles.
module note_tick_gen #(
  parameter int PERIOD = 50
) (
  input  logic clock,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(PERIOD - 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == TERMINAL) ? '0 : r_count + 1'b1;
    end
  end

  assign o_tick = i_en && (r_count == TERMINAL);

endmodule

// File: rtl/song_recorder.sv
// Records one song from the live keyboard at the playback note rate and writes
// it to song memory: protection byte first, then notes 0..59.
module song_recorder
  import song_recorder_pkg::*;
#(
  parameter int CLOCK_FREQUENCY = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic       privateSel,
  input  logic [7:0] key,
  output logic       writeNote,
  output logic       protectionChange,
  output logic [7:0] inote,
  output logic [5:0] noteOffset,
  output logic       busy,
  output logic       done
);

  localparam int PERIOD = CLOCK_FREQUENCY / 2;
  localparam int GW = (HS_GAP_CYCLES > 1) ? $clog2(HS_GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST   = GW'(HS_GAP_CYCLES - 1);
  localparam logic [5:0]    LAST_INDEX = 6'(NOTES_PER_SONG - 1);

  rec_state_t    r_state, w_state_next;
  logic [7:0]    r_inote;
  logic [5:0]    r_offset;
  logic [5:0]    r_index;
  logic [GW-1:0] r_gap_cnt;
  logic          r_abort_pend;

  logic w_tick, w_tick_en, w_gap_last, w_abort_exit, w_hs_state;

  // The period counter runs through the handshakes so notes stay PERIOD apart.
  assign w_tick_en = (r_state == ST_RECORD) || (r_state == ST_NOTE_REQ) ||
                     (r_state == ST_NOTE_GAP);
  assign w_hs_state = (r_state == ST_PROT_REQ) || (r_state == ST_PROT_GAP) ||
                      (r_state == ST_NOTE_REQ) || (r_state == ST_NOTE_GAP);
  assign w_gap_last   = (r_gap_cnt == GAP_LAST);
  assign w_abort_exit = r_abort_pend || abort;

  note_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clock  (clock),
    .reset  (reset),
    .i_clr  (!w_tick_en),
    .i_en   (w_tick_en),
    .o_tick (w_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    writeNote        = 1'b0;
    protectionChange = 1'b0;
    busy             = 1'b1;
    done             = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_state_next = ST_PROT_REQ;
      end
      ST_PROT_REQ: begin
        protectionChange = 1'b1;
        w_state_next     = ST_PROT_GAP;
      end
      ST_PROT_GAP: begin
        if (w_gap_last) w_state_next = w_abort_exit ? ST_IDLE : ST_RECORD;
      end
      ST_RECORD: begin
        if (abort)       w_state_next = ST_IDLE;
        else if (w_tick) w_state_next = ST_NOTE_REQ;
      end
      ST_NOTE_REQ: begin
        writeNote    = 1'b1;
        w_state_next = ST_NOTE_GAP;
      end
      ST_NOTE_GAP: begin
        if (w_gap_last) begin
          if (w_abort_exit)              w_state_next = ST_IDLE;
          else if (r_index == LAST_INDEX) w_state_next = ST_DONE;
          else                           w_state_next = ST_RECORD;
        end
      end
      ST_DONE: begin
        done         = 1'b1;
        w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_inote      <= '0;
      r_offset     <= '0;
      r_index      <= '0;
      r_gap_cnt    <= '0;
      r_abort_pend <= 1'b0;
    end else begin
      if ((r_state == ST_PROT_GAP) || (r_state == ST_NOTE_GAP)) r_gap_cnt <= r_gap_cnt + 1'b1;
      else                                                      r_gap_cnt <= '0;

      if (w_state_next == ST_IDLE)   r_abort_pend <= 1'b0;
      else if (abort && w_hs_state)  r_abort_pend <= 1'b1;

      if (r_state == ST_IDLE && start) begin
        r_inote <= prot_byte(privateSel);
        r_index <= '0;
      end
      // Abort wins over a coincident tick: no partial note write.
      if (r_state == ST_RECORD && w_tick && !abort) begin
        r_inote  <= key;
        r_offset <= r_index;
      end
      if (r_state == ST_NOTE_GAP && w_state_next == ST_RECORD) r_index <= r_index + 1'b1;
    end
  end

  assign inote      = r_inote;
  assign noteOffset = r_offset;

endmodule

// File: tb/tb_song_recorder.sv
// Directed bench for song_recorder at CLOCK_FREQUENCY = 8 (note period 4 cycles).
module tb_song_recorder;

  localparam int MAXC = 300;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       privateSel = 1'b0;
  logic [7:0] key = 8'd0;
  logic       writeNote, protectionChange, busy, done;
  logic [7:0] inote;
  logic [5:0] noteOffset;

  int n_vec = 0;
  int n_err = 0;

  logic       wn_h [0:MAXC];
  logic       pc_h [0:MAXC];
  logic       dn_h [0:MAXC];
  logic       bz_h [0:MAXC];
  logic [5:0] off_h[0:MAXC];
  logic [7:0] in_h [0:MAXC];
  logic [7:0] mem  [0:63];
  logic [7:0] prot_mem;

  song_recorder #(.CLOCK_FREQUENCY(8)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .abort            (abort),
    .privateSel       (privateSel),
    .key              (key),
    .writeNote        (writeNote),
    .protectionChange (protectionChange),
    .inote            (inote),
    .noteOffset       (noteOffset),
    .busy             (busy),
    .done             (done)
  );

  always #5 clock = ~clock;

  // start is raised in cycle 0; cycle c is observed 1 time unit after the c-th edge.
  task automatic run(input bit rest, input bit priv, input int abort_at,
                     input int reset_at, input int restart_at, input int ncycles);
    for (int i = 0; i <= MAXC; i++) begin
      wn_h[i] = 0; pc_h[i] = 0; dn_h[i] = 0; bz_h[i] = 0; off_h[i] = 0; in_h[i] = 0;
    end
    for (int i = 0; i < 64; i++) mem[i] = 8'hAA;
    prot_mem   = 8'hAA;
    privateSel = priv;
    start      = 1'b1;
    abort      = 1'b0;
    reset      = 1'b0;
    key        = rest ? 8'd0 : 8'd1;
    for (int c = 1; c <= ncycles; c++) begin
      @(posedge clock);
      #1;
      wn_h[c] = writeNote; pc_h[c] = protectionChange; dn_h[c] = done;
      bz_h[c] = busy; off_h[c] = noteOffset; in_h[c] = inote;
      if (c >= 2 && wn_h[c-2]) mem[off_h[c]] = in_h[c];
      if (c >= 2 && pc_h[c-2]) prot_mem = in_h[c];
      start = (c == restart_at);
      abort = (c == abort_at);
      reset = (c == reset_at);
      key   = rest ? 8'd0 : ((c < 4) ? 8'd1 : 8'((c - 4) / 4 + 1));
    end
    start = 1'b0; abort = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_vec++; if (writeNote !== 1'b0) begin n_err++; $display("FAIL reset_wn got %b want 0", writeNote); end
    n_vec++; if (protectionChange !== 1'b0) begin n_err++; $display("FAIL reset_pc got %b want 0", protectionChange); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
    n_vec++; if (inote !== 8'd0) begin n_err++; $display("FAIL reset_inote got %0d want 0", inote); end
    n_vec++; if (noteOffset !== 6'd0) begin n_err++; $display("FAIL reset_off got %0d want 0", noteOffset); end
    reset = 1'b0;
    @(posedge clock);
    #1;
    $display("reset: outputs checked");
  endtask

  task automatic test_full_record();
    logic exp_wn;
    int   k;
    run(1'b0, 1'b1, -1, -1, -1, 252);
    for (int c = 1; c <= 250; c++) begin
      exp_wn = (c >= 8) && (c <= 244) && ((c - 8) % 4 == 0);
      n_vec++; if (wn_h[c] !== exp_wn) begin n_err++; $display("FAIL full_wn c=%0d got %b want %b", c, wn_h[c], exp_wn); end
      n_vec++; if (pc_h[c] !== (c == 1)) begin n_err++; $display("FAIL full_pc c=%0d got %b want %b", c, pc_h[c], c == 1); end
      n_vec++; if (dn_h[c] !== (c == 247)) begin n_err++; $display("FAIL full_done c=%0d got %b want %b", c, dn_h[c], c == 247); end
      n_vec++; if (bz_h[c] !== (c <= 247)) begin n_err++; $display("FAIL full_busy c=%0d got %b want %b", c, bz_h[c], c <= 247); end
      if (c >= 8 && c <= 246 && ((c - 8) % 4) <= 2) begin
        k = (c - 8) / 4;
        n_vec++; if (off_h[c] !== 6'(k)) begin n_err++; $display("FAIL full_off c=%0d got %0d want %0d", c, off_h[c], k); end
        n_vec++; if (in_h[c] !== 8'(k + 1)) begin n_err++; $display("FAIL full_inote c=%0d got %0d want %0d", c, in_h[c], k + 1); end
      end
      if (c <= 3) begin
        n_vec++; if (in_h[c] !== 8'd1) begin n_err++; $display("FAIL full_prot_inote c=%0d got %0d want 1", c, in_h[c]); end
      end
    end
    for (int i = 0; i < 60; i++) begin
      n_vec++; if (mem[i] !== 8'(i + 1)) begin n_err++; $display("FAIL full_mem[%0d] got %0d want %0d", i, mem[i], i + 1); end
    end
    n_vec++; if (prot_mem !== 8'd1) begin n_err++; $display("FAIL full_prot_mem got %0d want 1", prot_mem); end
    $display("full_record: 60 notes private, done expected at cycle 247");
  endtask

  task automatic test_rest_public();
    int nwn;
    nwn = 0;
    run(1'b1, 1'b0, -1, -1, -1, 252);
    for (int c = 1; c <= 252; c++) if (wn_h[c] === 1'b1) nwn++;
    n_vec++; if (nwn !== 60) begin n_err++; $display("FAIL rest_wn_count got %0d want 60", nwn); end
    n_vec++; if (pc_h[1] !== 1'b1) begin n_err++; $display("FAIL rest_pc got %b want 1", pc_h[1]); end
    n_vec++; if (in_h[1] !== 8'd0) begin n_err++; $display("FAIL rest_prot_inote got %0d want 0", in_h[1]); end
    n_vec++; if (prot_mem !== 8'd0) begin n_err++; $display("FAIL rest_prot_mem got %0d want 0", prot_mem); end
    n_vec++; if (dn_h[247] !== 1'b1) begin n_err++; $display("FAIL rest_done got %b want 1", dn_h[247]); end
    for (int i = 0; i < 60; i++) begin
      n_vec++; if (mem[i] !== 8'd0) begin n_err++; $display("FAIL rest_mem[%0d] got %0d want 0", i, mem[i]); end
    end
    $display("rest_public: 60 rests public");
  endtask

  task automatic test_abort_record();
    int nwn, ndone;
    nwn = 0; ndone = 0;
    run(1'b0, 1'b1, 47, -1, -1, 60);
    for (int c = 1; c <= 60; c++) begin
      if (wn_h[c] === 1'b1) nwn++;
      if (dn_h[c] === 1'b1) ndone++;
    end
    n_vec++; if (nwn !== 10) begin n_err++; $display("FAIL abrec_wn_count got %0d want 10", nwn); end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL abrec_done_count got %0d want 0", ndone); end
    n_vec++; if (off_h[44] !== 6'd9) begin n_err++; $display("FAIL abrec_last_off got %0d want 9", off_h[44]); end
    n_vec++; if (bz_h[47] !== 1'b1) begin n_err++; $display("FAIL abrec_busy47 got %b want 1", bz_h[47]); end
    n_vec++; if (bz_h[48] !== 1'b0) begin n_err++; $display("FAIL abrec_busy48 got %b want 0", bz_h[48]); end
    n_vec++; if (wn_h[48] !== 1'b0) begin n_err++; $display("FAIL abrec_wn48 got %b want 0", wn_h[48]); end
    $display("abort_record: abort at index 10 in RECORD");
  endtask

  task automatic test_abort_handshake();
    int nwn, ndone;
    nwn = 0; ndone = 0;
    run(1'b0, 1'b1, 28, -1, -1, 40);
    for (int c = 1; c <= 40; c++) begin
      if (wn_h[c] === 1'b1) nwn++;
      if (dn_h[c] === 1'b1) ndone++;
    end
    n_vec++; if (wn_h[28] !== 1'b1) begin n_err++; $display("FAIL abhs_wn28 got %b want 1", wn_h[28]); end
    for (int c = 28; c <= 30; c++) begin
      n_vec++; if (off_h[c] !== 6'd5) begin n_err++; $display("FAIL abhs_off c=%0d got %0d want 5", c, off_h[c]); end
      n_vec++; if (in_h[c] !== 8'd6) begin n_err++; $display("FAIL abhs_inote c=%0d got %0d want 6", c, in_h[c]); end
    end
    n_vec++; if (bz_h[30] !== 1'b1) begin n_err++; $display("FAIL abhs_busy30 got %b want 1", bz_h[30]); end
    n_vec++; if (bz_h[31] !== 1'b0) begin n_err++; $display("FAIL abhs_busy31 got %b want 0", bz_h[31]); end
    n_vec++; if (nwn !== 6) begin n_err++; $display("FAIL abhs_wn_count got %0d want 6", nwn); end
    n_vec++; if (ndone !== 0) begin n_err++; $display("FAIL abhs_done_count got %0d want 0", ndone); end
    n_vec++; if (mem[5] !== 8'd6) begin n_err++; $display("FAIL abhs_mem5 got %0d want 6", mem[5]); end
    $display("abort_handshake: abort during NOTE_REQ at index 5");
  endtask

  task automatic test_restart_and_reset();
    int npc;
    npc = 0;
    run(1'b0, 1'b1, -1, 128, 20, 140);
    for (int c = 1; c <= 140; c++) if (pc_h[c] === 1'b1) npc++;
    n_vec++; if (npc !== 1) begin n_err++; $display("FAIL rst_pc_count got %0d want 1", npc); end
    n_vec++; if (off_h[28] !== 6'd5) begin n_err++; $display("FAIL rst_off28 got %0d want 5", off_h[28]); end
    n_vec++; if (wn_h[128] !== 1'b1 || off_h[128] !== 6'd30) begin n_err++; $display("FAIL rst_wn128 got %b/%0d want 1/30", wn_h[128], off_h[128]); end
    n_vec++; if (bz_h[129] !== 1'b0) begin n_err++; $display("FAIL rst_busy got %b want 0", bz_h[129]); end
    n_vec++; if (wn_h[129] !== 1'b0) begin n_err++; $display("FAIL rst_wn got %b want 0", wn_h[129]); end
    n_vec++; if (in_h[129] !== 8'd0) begin n_err++; $display("FAIL rst_inote got %0d want 0", in_h[129]); end
    n_vec++; if (off_h[129] !== 6'd0) begin n_err++; $display("FAIL rst_off got %0d want 0", off_h[129]); end
    n_vec++; if (dn_h[129] !== 1'b0 || pc_h[129] !== 1'b0) begin n_err++; $display("FAIL rst_done_pc got %b/%b want 0/0", dn_h[129], pc_h[129]); end
    n_vec++; if (bz_h[138] !== 1'b0) begin n_err++; $display("FAIL rst_idle got %b want 0", bz_h[138]); end
    run(1'b0, 1'b0, -1, -1, -1, 12);
    n_vec++; if (pc_h[1] !== 1'b1 || in_h[1] !== 8'd0) begin n_err++; $display("FAIL rst_new_prot got %b/%0d want 1/0", pc_h[1], in_h[1]); end
    n_vec++; if (wn_h[8] !== 1'b1) begin n_err++; $display("FAIL rst_new_wn got %b want 1", wn_h[8]); end
    n_vec++; if (off_h[8] !== 6'd0 || in_h[8] !== 8'd1) begin n_err++; $display("FAIL rst_new_note got %0d/%0d want 0/1", off_h[8], in_h[8]); end
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    $display("restart_and_reset: restart ignored, reset at index 30, new record from offset 0");
  endtask

  initial begin
    test_reset();
    test_full_record();
    test_rest_public();
    test_abort_record();
    test_abort_handshake();
    test_restart_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
